// File: rtl/operand_forward_pipe_pkg.sv
// Shared definitions for the operand forwarding datapath: forward-select codes,
// ALU operation codes used by control, link register number and the control bundle.
package operand_forward_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF       = 2'b00,
    FWD_EXE      = 2'b01,
    FWD_MEM_ALU  = 2'b10,
    FWD_MEM_LOAD = 2'b11
  } fwd_sel_e;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam int LINK_REG = 31;

  // Decoded control fields carried down the pipe; all-zero encodes a bubble.
  typedef struct packed {
    logic       wreg;
    logic       mem2reg;
    logic       wmem;
    logic [3:0] aluc;
    logic       aluimm;
    logic       shift;
    logic       jal;
  } ctrl_t;

endpackage

// File: rtl/operand_forward_pipe_if.sv
// Bundle between control/decoder/ALU/memory and the forwarding datapath.
// master = surrounding pipeline, slave = operand_forward_pipe.
interface operand_forward_pipe_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          id_wreg;
  logic          id_mem2reg;
  logic          id_wmem;
  logic [3:0]    id_aluc;
  logic          id_aluimm;
  logic          id_shift;
  logic          id_jal;
  logic [AW-1:0] id_regw_addr;
  logic          stall;
  logic [1:0]    fwda;
  logic [1:0]    fwdb;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [DW-1:0] id_sa;
  logic [DW-1:0] id_pc8;
  logic [DW-1:0] exe_alu_res;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] id_opa;
  logic [DW-1:0] id_opb;
  logic          rsrtequ;
  logic          exe_wreg;
  logic          exe_mem2reg;
  logic          exe_wmem;
  logic          exe_aluimm;
  logic          exe_shift;
  logic          exe_jal;
  logic [3:0]    exe_aluc;
  logic [AW-1:0] exe_regw_addr;
  logic [DW-1:0] exe_a;
  logic [DW-1:0] exe_b;
  logic [DW-1:0] exe_imm;
  logic [DW-1:0] exe_sa;
  logic [DW-1:0] exe_pc8;
  logic          mem_wreg;
  logic          mem_mem2reg;
  logic          mem_wmem;
  logic [AW-1:0] mem_regw_addr;
  logic [DW-1:0] mem_alu_res;
  logic [DW-1:0] mem_wdata;

  modport master (
    output id_wreg, id_mem2reg, id_wmem, id_aluc, id_aluimm, id_shift, id_jal,
           id_regw_addr, stall, fwda, fwdb, id_rs_data, id_rt_data, id_imm,
           id_sa, id_pc8, exe_alu_res, mem_rdata,
    input  id_opa, id_opb, rsrtequ, exe_wreg, exe_mem2reg, exe_wmem, exe_aluimm,
           exe_shift, exe_jal, exe_aluc, exe_regw_addr, exe_a, exe_b, exe_imm,
           exe_sa, exe_pc8, mem_wreg, mem_mem2reg, mem_wmem, mem_regw_addr,
           mem_alu_res, mem_wdata
  );

  modport slave (
    input  id_wreg, id_mem2reg, id_wmem, id_aluc, id_aluimm, id_shift, id_jal,
           id_regw_addr, stall, fwda, fwdb, id_rs_data, id_rt_data, id_imm,
           id_sa, id_pc8, exe_alu_res, mem_rdata,
    output id_opa, id_opb, rsrtequ, exe_wreg, exe_mem2reg, exe_wmem, exe_aluimm,
           exe_shift, exe_jal, exe_aluc, exe_regw_addr, exe_a, exe_b, exe_imm,
           exe_sa, exe_pc8, mem_wreg, mem_mem2reg, mem_wmem, mem_regw_addr,
           mem_alu_res, mem_wdata
  );
endinterface

// File: rtl/operand_forward_pipe_fwd_mux4.sv
// DW-wide 4:1 operand select driven by a forward code.
// Latency: combinational. Backpressure: none.
// Selection is purely by code; validity of the chosen source is the caller's concern.
module fwd_mux4
  import operand_forward_pipe_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    sel,
  input  logic [DW-1:0] rf_dat,
  input  logic [DW-1:0] exe_dat,
  input  logic [DW-1:0] mem_alu_dat,
  input  logic [DW-1:0] mem_load_dat,
  output logic [DW-1:0] y
);

  always_comb begin
    y = rf_dat;
    case (sel)
      FWD_EXE:      y = exe_dat;
      FWD_MEM_ALU:  y = mem_alu_dat;
      FWD_MEM_LOAD: y = mem_load_dat;
      default:      y = rf_dat;
    endcase
  end

endmodule

// File: rtl/operand_forward_pipe.sv
// Forwarded ID operands plus ID/EXE and EXE/MEM pipeline registers.
// Latency: id_opa/id_opb combinational; exe_* 1 cycle, mem_* 2 cycles after ID.
// Backpressure: stall injects a bubble into EXE; EXE/MEM is never held.
module operand_forward_pipe
  import operand_forward_pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  operand_forward_pipe_if.slave bus
);

  ctrl_t         id_ctrl;
  ctrl_t         exe_ctrl;
  logic [AW-1:0] exe_rd;
  logic [DW-1:0] exe_a_q;
  logic [DW-1:0] exe_b_q;
  logic [DW-1:0] exe_imm_q;
  logic [DW-1:0] exe_sa_q;
  logic [DW-1:0] exe_pc8_q;

  logic          mem_wreg_q;
  logic          mem_mem2reg_q;
  logic          mem_wmem_q;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_res_q;
  logic [DW-1:0] mem_wdata_q;

  logic [DW-1:0] exe_res;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;

  // A jal in EXE produces its link address, not the ALU output.
  assign exe_res = exe_ctrl.jal ? exe_pc8_q : bus.exe_alu_res;

  fwd_mux4 #(.DW(DW)) u_mux_a (
    .sel          (bus.fwda),
    .rf_dat       (bus.id_rs_data),
    .exe_dat      (exe_res),
    .mem_alu_dat  (mem_res_q),
    .mem_load_dat (bus.mem_rdata),
    .y            (opa)
  );

  fwd_mux4 #(.DW(DW)) u_mux_b (
    .sel          (bus.fwdb),
    .rf_dat       (bus.id_rt_data),
    .exe_dat      (exe_res),
    .mem_alu_dat  (mem_res_q),
    .mem_load_dat (bus.mem_rdata),
    .y            (opb)
  );

  assign bus.id_opa  = opa;
  assign bus.id_opb  = opb;
  assign bus.rsrtequ = (opa == opb);

  assign id_ctrl = '{
    wreg:    bus.id_wreg,
    mem2reg: bus.id_mem2reg,
    wmem:    bus.id_wmem,
    aluc:    bus.id_aluc,
    aluimm:  bus.id_aluimm,
    shift:   bus.id_shift,
    jal:     bus.id_jal
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_ctrl  <= '0;
      exe_rd    <= '0;
      exe_a_q   <= '0;
      exe_b_q   <= '0;
      exe_imm_q <= '0;
      exe_sa_q  <= '0;
      exe_pc8_q <= '0;
    end else if (bus.stall) begin
      exe_ctrl  <= '0;
      exe_rd    <= '0;
      exe_a_q   <= '0;
      exe_b_q   <= '0;
      exe_imm_q <= '0;
      exe_sa_q  <= '0;
      exe_pc8_q <= '0;
    end else begin
      exe_ctrl  <= id_ctrl;
      exe_rd    <= bus.id_jal ? AW'(LINK_REG) : bus.id_regw_addr;
      exe_a_q   <= opa;
      exe_b_q   <= opb;
      exe_imm_q <= bus.id_imm;
      exe_sa_q  <= bus.id_sa;
      exe_pc8_q <= bus.id_pc8;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wreg_q    <= 1'b0;
      mem_mem2reg_q <= 1'b0;
      mem_wmem_q    <= 1'b0;
      mem_rd        <= '0;
      mem_res_q     <= '0;
      mem_wdata_q   <= '0;
    end else begin
      mem_wreg_q    <= exe_ctrl.wreg;
      mem_mem2reg_q <= exe_ctrl.mem2reg;
      mem_wmem_q    <= exe_ctrl.wmem;
      mem_rd        <= exe_rd;
      mem_res_q     <= exe_res;
      mem_wdata_q   <= exe_b_q;
    end
  end

  assign bus.exe_wreg      = exe_ctrl.wreg;
  assign bus.exe_mem2reg   = exe_ctrl.mem2reg;
  assign bus.exe_wmem      = exe_ctrl.wmem;
  assign bus.exe_aluimm    = exe_ctrl.aluimm;
  assign bus.exe_shift     = exe_ctrl.shift;
  assign bus.exe_jal       = exe_ctrl.jal;
  assign bus.exe_aluc      = exe_ctrl.aluc;
  assign bus.exe_regw_addr = exe_rd;
  assign bus.exe_a         = exe_a_q;
  assign bus.exe_b         = exe_b_q;
  assign bus.exe_imm       = exe_imm_q;
  assign bus.exe_sa        = exe_sa_q;
  assign bus.exe_pc8       = exe_pc8_q;

  assign bus.mem_wreg      = mem_wreg_q;
  assign bus.mem_mem2reg   = mem_mem2reg_q;
  assign bus.mem_wmem      = mem_wmem_q;
  assign bus.mem_regw_addr = mem_rd;
  assign bus.mem_alu_res   = mem_res_q;
  assign bus.mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_operand_forward_pipe.sv
// Bench for operand_forward_pipe: directed scenarios plus randomized traffic
// checked against a stage-occupancy reference model.
module tb_operand_forward_pipe;
  import operand_forward_pipe_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst_n;

  operand_forward_pipe_if #(.DW(DW), .AW(AW)) bus ();

  operand_forward_pipe #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // What the model believes occupies each stage.
  typedef struct packed {
    logic        wreg, mem2reg, wmem, aluimm, shift, jal;
    logic [3:0]  aluc;
    logic [4:0]  rd;
    logic [31:0] a, b, imm, sa, pc8;
  } exe_m_t;

  typedef struct packed {
    logic        wreg, mem2reg, wmem;
    logic [4:0]  rd;
    logic [31:0] res, wdata;
  } mem_m_t;

  exe_m_t m_exe;
  mem_m_t m_mem;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

  // Value an instruction in EXE would hand to a consumer.
  function automatic logic [31:0] exe_value();
    return m_exe.jal ? m_exe.pc8 : bus.exe_alu_res;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf);
    case (sel)
      2'b00:   return rf;
      2'b01:   return exe_value();
      2'b10:   return m_mem.res;
      default: return bus.mem_rdata;
    endcase
  endfunction

  function automatic logic [174:0] exe_dut();
    return {bus.exe_wreg, bus.exe_mem2reg, bus.exe_wmem, bus.exe_aluimm, bus.exe_shift,
            bus.exe_jal, bus.exe_aluc, bus.exe_regw_addr, bus.exe_a, bus.exe_b,
            bus.exe_imm, bus.exe_sa, bus.exe_pc8};
  endfunction

  function automatic logic [71:0] mem_dut();
    return {bus.mem_wreg, bus.mem_mem2reg, bus.mem_wmem, bus.mem_regw_addr,
            bus.mem_alu_res, bus.mem_wdata};
  endfunction

  task automatic clear_id();
    bus.id_wreg = 0; bus.id_mem2reg = 0; bus.id_wmem = 0; bus.id_aluc = 0;
    bus.id_aluimm = 0; bus.id_shift = 0; bus.id_jal = 0; bus.id_regw_addr = 0;
    bus.stall = 0; bus.fwda = 0; bus.fwdb = 0; bus.id_rs_data = 0; bus.id_rt_data = 0;
    bus.id_imm = 0; bus.id_sa = 0; bus.id_pc8 = 0; bus.exe_alu_res = 0; bus.mem_rdata = 0;
  endtask

  // Advance one clock; the model moves the ID instruction into EXE and EXE into MEM.
  task automatic tick();
    exe_m_t nx;
    mem_m_t nm;
    nm = '{wreg: m_exe.wreg, mem2reg: m_exe.mem2reg, wmem: m_exe.wmem, rd: m_exe.rd,
           res: exe_value(), wdata: m_exe.b};
    nx = '0;
    if (!bus.stall) begin
      nx.wreg = bus.id_wreg;       nx.mem2reg = bus.id_mem2reg; nx.wmem = bus.id_wmem;
      nx.aluimm = bus.id_aluimm;   nx.shift = bus.id_shift;     nx.jal = bus.id_jal;
      nx.aluc = bus.id_aluc;
      nx.rd = bus.id_jal ? 5'd31 : bus.id_regw_addr;
      nx.a = ref_fwd(bus.fwda, bus.id_rs_data);
      nx.b = ref_fwd(bus.fwdb, bus.id_rt_data);
      nx.imm = bus.id_imm; nx.sa = bus.id_sa; nx.pc8 = bus.id_pc8;
    end
    @(posedge clk);
    m_exe = nx;
    m_mem = nm;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_id();
    m_exe = '0;
    m_mem = '0;
    #1;
    checks++;
    if (exe_dut() !== 175'd0) begin
      errors++; $display("FAIL reset_exe: got %h want 0", exe_dut());
    end
    checks++;
    if (mem_dut() !== 72'd0) begin
      errors++; $display("FAIL reset_mem: got %h want 0", mem_dut());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Mid-run reset with a writer in EXE and MEM.
    bus.id_wreg = 1; bus.id_regw_addr = 5'd9; bus.id_rs_data = 32'h77;
    tick();
    tick();
    checks++;
    if (bus.exe_wreg !== 1'b1 || bus.mem_wreg !== 1'b1) begin
      errors++; $display("FAIL reset_prefill: exe_wreg %b mem_wreg %b want 1 1", bus.exe_wreg, bus.mem_wreg);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (exe_dut() !== 175'd0 || mem_dut() !== 72'd0) begin
      errors++; $display("FAIL reset_async: exe %h mem %h want all 0", exe_dut(), mem_dut());
    end
    m_exe = '0;
    m_mem = '0;
    #1 rst_n = 1'b1;
    clear_id();
  endtask

  task automatic test_exe_forward();
    clear_id();
    tick();
    bus.fwda = 2'b01; bus.exe_alu_res = 32'h0000_1234; bus.id_rs_data = 32'h0000_DEAD;
    bus.id_wreg = 1; bus.id_regw_addr = 5'd4;
    #1;
    checks++;
    if (bus.id_opa !== 32'h0000_1234) begin
      errors++; $display("FAIL exe_fwd_opa: got %h want 00001234", bus.id_opa);
    end
    tick();
    checks++;
    if (bus.exe_a !== 32'h0000_1234) begin
      errors++; $display("FAIL exe_fwd_exe_a: got %h want 00001234", bus.exe_a);
    end
  endtask

  task automatic test_load_forward();
    clear_id();
    bus.fwdb = 2'b11; bus.mem_rdata = 32'hCAFE_F00D; bus.id_rs_data = 32'hCAFE_F00D;
    #1;
    checks++;
    if (bus.id_opb !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL load_fwd_opb: got %h want cafef00d", bus.id_opb);
    end
    checks++;
    if (bus.rsrtequ !== 1'b1) begin
      errors++; $display("FAIL load_fwd_equ: got %b want 1", bus.rsrtequ);
    end
    bus.mem_rdata = 32'hCAFE_F00C;
    #1;
    checks++;
    if (bus.rsrtequ !== 1'b0) begin
      errors++; $display("FAIL load_fwd_nequ: got %b want 0", bus.rsrtequ);
    end
    tick();
  endtask

  task automatic test_stall();
    clear_id();
    bus.id_wreg = 1; bus.id_regw_addr = 5'd3; bus.id_rt_data = 32'h55;
    tick();
    clear_id();
    bus.stall = 1; bus.id_wreg = 1; bus.id_regw_addr = 5'd7; bus.exe_alu_res = 32'hABC;
    tick();
    checks++;
    if (bus.exe_wreg !== 1'b0 || bus.exe_regw_addr !== 5'd0) begin
      errors++; $display("FAIL stall_bubble: exe_wreg %b rd %0d want 0 0", bus.exe_wreg, bus.exe_regw_addr);
    end
    checks++;
    if ({bus.mem_wreg, bus.mem_regw_addr, bus.mem_alu_res, bus.mem_wdata} !== {1'b1, 5'd3, 32'hABC, 32'h55}) begin
      errors++; $display("FAIL stall_mem_pass: wreg %b rd %0d res %h wdata %h want 1 3 abc 55",
                         bus.mem_wreg, bus.mem_regw_addr, bus.mem_alu_res, bus.mem_wdata);
    end
    clear_id();
  endtask

  task automatic test_jal();
    clear_id();
    bus.id_jal = 1; bus.id_wreg = 1; bus.id_pc8 = 32'h0040_0010; bus.id_regw_addr = 5'd5;
    tick();
    checks++;
    if (bus.exe_regw_addr !== 5'd31 || bus.exe_jal !== 1'b1) begin
      errors++; $display("FAIL jal_rd: rd %0d jal %b want 31 1", bus.exe_regw_addr, bus.exe_jal);
    end
    clear_id();
    bus.fwda = 2'b01; bus.exe_alu_res = 32'h1111_1111;
    #1;
    checks++;
    if (bus.id_opa !== 32'h0040_0010) begin
      errors++; $display("FAIL jal_fwd: got %h want 00400010", bus.id_opa);
    end
    tick();
    checks++;
    if (bus.mem_alu_res !== 32'h0040_0010 || bus.mem_regw_addr !== 5'd31) begin
      errors++; $display("FAIL jal_mem: res %h rd %0d want 00400010 31", bus.mem_alu_res, bus.mem_regw_addr);
    end
    clear_id();
  endtask

  task automatic test_back_to_back();
    clear_id();
    bus.id_wreg = 1; bus.id_aluc = ALUC_ADD; bus.id_regw_addr = 5'd1;
    bus.id_rs_data = 32'd10; bus.id_rt_data = 32'd20;
    tick();
    // add1 in EXE produces 30; add2 consumes it from EXE.
    bus.exe_alu_res = 32'd30; bus.id_regw_addr = 5'd2; bus.fwda = 2'b01;
    bus.id_rs_data = 32'hDEAD; bus.id_rt_data = 32'd5;
    #1;
    checks++;
    if (bus.id_opa !== 32'd30 || bus.exe_wreg !== 1'b1) begin
      errors++; $display("FAIL b2b_first: opa %0d exe_wreg %b want 30 1", bus.id_opa, bus.exe_wreg);
    end
    tick();
    // add2 in EXE produces 35; add3 consumes add1 from MEM.
    bus.exe_alu_res = 32'd35; bus.id_regw_addr = 5'd3; bus.fwda = 2'b10;
    #1;
    checks++;
    if (bus.id_opa !== 32'd30 || bus.exe_wreg !== 1'b1) begin
      errors++; $display("FAIL b2b_second: opa %0d exe_wreg %b want 30 1", bus.id_opa, bus.exe_wreg);
    end
    tick();
    checks++;
    if (bus.exe_wreg !== 1'b1 || bus.exe_a !== 32'd30 || bus.mem_alu_res !== 32'd35) begin
      errors++; $display("FAIL b2b_third: exe_wreg %b exe_a %0d mem_res %0d want 1 30 35",
                         bus.exe_wreg, bus.exe_a, bus.mem_alu_res);
    end
    clear_id();
  endtask

  task automatic test_random();
    logic [31:0] ea, eb;
    for (int i = 0; i < 400; i++) begin
      bus.id_wreg = 1'($urandom);   bus.id_mem2reg = 1'($urandom); bus.id_wmem = 1'($urandom);
      bus.id_aluc = 4'($urandom);   bus.id_aluimm = 1'($urandom);  bus.id_shift = 1'($urandom);
      bus.id_jal = ($urandom_range(0, 5) == 0);
      bus.id_regw_addr = 5'($urandom);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.fwda = 2'($urandom); bus.fwdb = 2'($urandom);
      bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
      bus.id_imm = $urandom; bus.id_sa = 32'($urandom_range(0, 31)); bus.id_pc8 = $urandom;
      bus.exe_alu_res = $urandom; bus.mem_rdata = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        bus.fwda = 2'b00; bus.fwdb = 2'b00; bus.id_rt_data = bus.id_rs_data;
      end
      #1;
      ea = ref_fwd(bus.fwda, bus.id_rs_data);
      eb = ref_fwd(bus.fwdb, bus.id_rt_data);
      checks++;
      if (bus.id_opa !== ea || bus.id_opb !== eb || bus.rsrtequ !== (ea == eb)) begin
        errors++; $display("FAIL rand_fwd[%0d]: opa %h opb %h equ %b want %h %h %b",
                           i, bus.id_opa, bus.id_opb, bus.rsrtequ, ea, eb, (ea == eb));
      end
      tick();
      checks++;
      if (exe_dut() !== m_exe) begin
        errors++; $display("FAIL rand_exe[%0d]: got %h want %h", i, exe_dut(), m_exe);
      end
      checks++;
      if (mem_dut() !== m_mem) begin
        errors++; $display("FAIL rand_mem[%0d]: got %h want %h", i, mem_dut(), m_mem);
      end
    end
    clear_id();
  endtask

  initial begin
    test_reset();
    test_exe_forward();
    test_load_forward();
    test_stall();
    test_jal();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
